// File: rtl/prog_mem_if.sv
// Fetch port and byte-wide image load stream of the TW4 program memory.
// master = CPU/loader side, slave = prog_mem.
interface prog_mem_if #(
    parameter int ADDR_W = 6
);
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [7:0]        data_t;

    addr_t addr;
    data_t data;
    logic  ld_start;
    logic  ld_valid;
    data_t ld_byte;
    logic  ld_ready;
    logic  cpu_run;
    logic  ld_error;

    modport master (
        output addr, ld_start, ld_valid, ld_byte,
        input  data, ld_ready, cpu_run, ld_error
    );

    modport slave (
        input  addr, ld_start, ld_valid, ld_byte,
        output data, ld_ready, cpu_run, ld_error
    );
endinterface

// File: rtl/prog_mem.sv
// TW4 program memory plus image loader FSM gating cpu_run.
// Define PROG_MEM_CHECKSUM_EN for the trailing checksum byte and ld_error.
module prog_mem #(
    parameter int ADDR_W = 6
) (
    input logic       clock,
    input logic       reset,
    prog_mem_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
`ifdef PROG_MEM_CHECKSUM_EN
        CHECK = 3'd2,
        ERROR = 3'd4,
`endif
        RUN   = 3'd3
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic [7:0]        mem [DEPTH];
    logic              we;
    logic              xfer;
    logic              last;
    logic              ready_q, ready_n;
    logic              run_q, run_n;

`ifdef PROG_MEM_CHECKSUM_EN
    logic [7:0] sum, sum_n;
    logic [7:0] ck;
    logic       err_q, err_n;

    assign ck = sum + bus.ld_byte;
`endif

    assign xfer = bus.ld_valid && ready_q;
    assign last = (cnt == {ADDR_W{1'b1}});

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        we      = 1'b0;
`ifdef PROG_MEM_CHECKSUM_EN
        sum_n   = sum;
`endif
        unique case (state)
            IDLE: begin
                if (bus.ld_start) begin
                    state_n = LOAD;
                    cnt_n   = '0;
`ifdef PROG_MEM_CHECKSUM_EN
                    sum_n   = '0;
`endif
                end
            end
            LOAD: begin
                if (xfer) begin
                    we    = 1'b1;
                    cnt_n = cnt + ADDR_W'(1);
`ifdef PROG_MEM_CHECKSUM_EN
                    sum_n = ck;
                    if (last) state_n = CHECK;
`else
                    if (last) state_n = RUN;
`endif
                end
            end
`ifdef PROG_MEM_CHECKSUM_EN
            CHECK: begin
                if (xfer) state_n = (ck == 8'h00) ? RUN : ERROR;
            end
            RUN, ERROR: begin
`else
            RUN: begin
`endif
                // Reload drops cpu_run, which resets the CPU.
                if (bus.ld_start) begin
                    state_n = LOAD;
                    cnt_n   = '0;
`ifdef PROG_MEM_CHECKSUM_EN
                    sum_n   = '0;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ready_n = 1'b0;
        run_n   = 1'b0;
`ifdef PROG_MEM_CHECKSUM_EN
        err_n   = 1'b0;
`endif
        unique case (1'b1)
            (state_n == LOAD):  ready_n = 1'b1;
`ifdef PROG_MEM_CHECKSUM_EN
            (state_n == CHECK): ready_n = 1'b1;
            (state_n == ERROR): err_n   = 1'b1;
`endif
            (state_n == RUN):   run_n   = 1'b1;
            default:            ready_n = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            ready_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            ready_q <= ready_n;
            run_q   <= run_n;
        end
    end

`ifdef PROG_MEM_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            sum   <= '0;
            err_q <= 1'b0;
        end else begin
            sum   <= sum_n;
            err_q <= err_n;
        end
    end

    assign bus.ld_error = err_q;
`else
    assign bus.ld_error = 1'b0;
`endif

    // Contents survive reset; only the write on a reset edge is blocked.
    always_ff @(posedge clock) begin
        if (we && reset) mem[cnt] <= bus.ld_byte;
    end

    assign bus.ld_ready = ready_q;
    assign bus.cpu_run  = run_q;
    assign bus.data     = run_q ? mem[bus.addr] : 8'h00;
endmodule

// File: tb/tb_prog_mem.sv
// Directed/random bench for prog_mem against a byte-queue image model.
// Builds with or without PROG_MEM_CHECKSUM_EN.
module tb_prog_mem;
    localparam int AW = 6;
    localparam int N  = 1 << AW;
`ifdef PROG_MEM_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    prog_mem_if #(.ADDR_W(AW)) bus ();

    prog_mem #(.ADDR_W(AW)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_mem [N];
    bit         m_ready, m_run, m_err, m_chk;
    int         m_cnt;
    logic [7:0] m_sum;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        chk({tag, ".ld_ready"}, {7'b0, bus.ld_ready}, {7'b0, m_ready});
        chk({tag, ".cpu_run"},  {7'b0, bus.cpu_run},  {7'b0, m_run});
        chk({tag, ".ld_error"}, {7'b0, bus.ld_error}, {7'b0, m_err});
    endtask

    // Image-level model: bytes accepted while loading, then optional checksum.
    task automatic model_edge(input bit st, input bit v,
                              input logic [7:0] b, input bit rst);
        if (!rst) begin
            m_ready = 0; m_run = 0; m_err = 0; m_chk = 0;
            m_cnt = 0; m_sum = 8'h00;
        end else if (m_ready) begin
            if (v) begin
                if (!m_chk) begin
                    m_mem[m_cnt] = b;
                    m_sum = m_sum + b;
                    m_cnt++;
                    if (m_cnt == N) begin
                        if (CK) m_chk = 1;
                        else begin m_ready = 0; m_run = 1; end
                    end
                end else begin
                    m_ready = 0;
                    m_chk = 0;
                    if (8'(m_sum + b) == 8'h00) m_run = 1;
                    else m_err = 1;
                end
            end
        end else if (st) begin
            m_ready = 1; m_run = 0; m_err = 0; m_chk = 0;
            m_cnt = 0; m_sum = 8'h00;
        end
    endtask

    task automatic cyc(input bit st, input bit v, input logic [7:0] b,
                       input string tag);
        bus.ld_start = st;
        bus.ld_valid = v;
        bus.ld_byte  = b;
        @(posedge clock);
        model_edge(st, v, b, reset);
        #1;
        check_flags(tag);
    endtask

    task automatic fetch(input logic [AW-1:0] a, input string tag);
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.addr = a;
        #1;
        chk(tag, bus.data, m_run ? m_mem[a] : 8'h00);
    endtask

    task automatic fetch_all(input string tag);
        for (int i = 0; i < N; i++) fetch(AW'(i), tag);
    endtask

    // mode 0: byte = index, 1: constant val, 2: random
    task automatic load_image(input int mode, input logic [7:0] val,
                              input bit gaps, input bit bad_ck,
                              input bit mid_start, input int abort_at);
        int guard;
        guard = 0;
        cyc(1'b1, 1'b0, 8'h00, "start");
        while (m_ready && guard < 1000) begin
            logic [7:0] b;
            bit         v;
            bit         st;
            guard++;
            if (abort_at > 0 && m_cnt == abort_at) break;
            if (m_chk) b = ~m_sum + 8'd1 + 8'(bad_ck);
            else if (mode == 0) b = 8'(m_cnt);
            else if (mode == 1) b = val;
            else b = 8'($urandom);
            v  = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            st = mid_start && (m_cnt == 20);
            cyc(st, v, b, "load");
        end
        checks++;
        if (guard >= 1000) begin
            failures++;
            $display("FAIL load_timeout observed=%0d required<1000", guard);
        end
    endtask

    initial begin
        bus.addr     = '0;
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_byte  = 8'h00;
        for (int i = 0; i < N; i++) m_mem[i] = 8'h00;

        reset = 1'b0;
        cyc(1'b0, 1'b0, 8'h00, "reset");
        cyc(1'b0, 1'b0, 8'h00, "reset");
        reset = 1'b1;
        fetch(AW'(5), "idle_data");

        for (int i = 0; i < 4; i++)
            cyc(1'b0, i[0], 8'hA5, "idle_valid");

        load_image(0, 8'h00, 1'b0, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b0, 8'h00, "run_hold");
        bus.addr = AW'(6'h15);
        #1;
        chk("run_addr15", bus.data, 8'h15);
        fetch(AW'(0), "run_a0");
        fetch(AW'(63), "run_a63");

        load_image(0, 8'h00, 1'b1, 1'b0, 1'b0, 0);
        fetch_all("gap_image");

        if (CK) begin
            load_image(1, 8'h01, 1'b0, 1'b0, 1'b0, 0);
            chk("ck_good_run", {7'b0, bus.cpu_run}, 8'h01);
            fetch(AW'(7), "ck_good_data");
            load_image(1, 8'h01, 1'b0, 1'b1, 1'b0, 0);
            chk("ck_bad_err", {7'b0, bus.ld_error}, 8'h01);
            for (int i = 0; i < 4; i++)
                fetch(AW'($urandom), "err_data");
        end

        load_image(1, 8'hFF, 1'b1, 1'b0, 1'b0, 0);
        bus.addr = AW'(6'h3F);
        #1;
        chk("ff_addr3f", bus.data, 8'hFF);

        load_image(2, 8'h00, 1'b0, 1'b0, 1'b0, 10);
        reset = 1'b0;
        cyc(1'b0, 1'b1, 8'h11, "mid_reset");
        reset = 1'b1;
        for (int i = 0; i < 4; i++)
            cyc(1'b0, ~i[0], 8'h5A, "post_rst_valid");
        fetch(AW'(3), "post_rst_data");

        load_image(2, 8'h00, 1'b1, 1'b0, 1'b1, 0);
        fetch_all("final_image");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
